serial_add_sequencer: RTL and testbench

//   Bit-serial add controller for the 4-bit accumulator path.
//   - Accepts two WIDTH-bit operands plus carry-in on a start pulse.
//   - Feeds them LSB-first through a single 1-bit full adder, one bit per clock, with a registered carry.
//   - Assembles the sum in a shift register; reports busy/done with a registered result.
//   - Sits between the debounced button pulses and the seven-segment decoder, replacing the parallel adder.

---
 rtl/serial_add_pkg.sv | 15 +
 rtl/full_adder_1bit.sv | 13 +
 rtl/serial_add_sequencer.sv | 126 ++++++++++++
 tb/tb_serial_add_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add controller: FSM state encoding
// and the default operand width.
package serial_add_pkg;

    // Default operand/result width for the accumulator path.
    localparam int DEFAULT_WIDTH = 4;

    // Controller states; the encoding is fixed so that debug taps stay stable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_e;

endpackage : serial_add_pkg

// File: rtl/full_adder_1bit.sv
// Single-bit full adder; the only arithmetic element of the serial datapath.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule : full_adder_1bit

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller: latches two operands and a carry-in on a start
// pulse, adds them LSB-first through one full adder with a registered carry,
// and publishes the assembled sum and carry-out together with a done pulse.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             acc_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [IDX_W-1:0] bit_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    sa_state_e        state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic             c_q;
    logic [IDX_W-1:0] bit_idx_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] s_sh_d;

    // The one shared full adder works on the current LSBs and the carry register.
    full_adder_1bit u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (c_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next partial sum: new bit enters at the MSB so the LSB ends at bit 0.
    always_comb begin
        s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};
    end

    // Controller FSM together with the datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            s_sh_q    <= '0;
            c_q       <= 1'b0;
            bit_idx_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Accumulate mode feeds back the result held right now.
                        a_sh_q    <= acc_mode ? sum_q : op_a;
                        b_sh_q    <= op_b;
                        c_q       <= cin;
                        s_sh_q    <= '0;
                        bit_idx_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    s_sh_q <= s_sh_d;
                    a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
                    c_q    <= fa_co;
                    if (bit_idx_q == LAST_IDX) begin
                        // Final bit: publish the result and flag completion.
                        sum_q     <= s_sh_d;
                        cout_q    <= fa_co;
                        bit_idx_q <= '0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        bit_idx_q <= bit_idx_q + IDX_ONE;
                        done_q    <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    bit_idx_q <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign bit_idx = bit_idx_q;

endmodule : serial_add_sequencer

// File: tb/tb_serial_add_sequencer.sv
// Directed and randomised checks of the serial add controller at WIDTH=4.
module tb_serial_add_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       acc_mode;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [3:0] sum;
    logic       cout;
    logic [1:0] bit_idx;

    int checks;
    int errors;

    serial_add_sequencer #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .acc_mode (acc_mode),
        .op_a     (op_a),
        .op_b     (op_b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .bit_idx  (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one add and observe 12 cycles after the accepting edge.
    // lat = cycles after accepting edge when done first seen (-1 if never).
    task automatic run_add(input logic [3:0] a, input logic [3:0] b,
                           input logic c, input logic m,
                           output int lat, output int busy_cyc,
                           output int done_cyc, output logic [9:0] idx_trace,
                           output logic [3:0] sum_mid);
        @(negedge clk);
        op_a = a; op_b = b; cin = c; acc_mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; busy_cyc = 0; done_cyc = 0; idx_trace = '0; sum_mid = '0;
        for (int j = 0; j < 12; j++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc++;
                if (lat < 0) lat = j;
            end
            if (j < 5) idx_trace[2*j +: 2] = bit_idx;
            if (j == 3) sum_mid = sum;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; acc_mode = 1'b0;
        op_a = 4'd0; op_b = 4'd0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 4'd0 || cout !== 1'b0 || bit_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%0d cout=%b idx=%0d, required all 0",
                     busy, done, sum, cout, bit_idx);
        end
        // rst and start on the same edge: reset must win.
        @(negedge clk);
        start = 1'b1; op_a = 4'd5; op_b = 4'd3;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_wins_start: busy=%b, required 0", busy);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_no_queue: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bc, dc;
        logic [9:0] tr;
        logic [3:0] mid;
        run_add(4'd5, 4'd3, 1'b0, 1'b0, lat, bc, dc, tr, mid);
        checks++;
        if (sum !== 4'd8 || cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_5p3: sum=%0d cout=%b, required 8 0", sum, cout);
        end
        checks++;
        if (lat !== 4 || dc !== 1) begin
            errors++;
            $display("FAIL basic_timing: latency=%0d done_cycles=%0d, required 4 1", lat, dc);
        end
        checks++;
        if (bc !== 5) begin
            errors++;
            $display("FAIL basic_busy: busy_cycles=%0d, required 5", bc);
        end
        checks++;
        if (tr !== 10'b00_11_10_01_00) begin
            errors++;
            $display("FAIL basic_bit_idx: trace=%b, required 0011100100", tr);
        end
        checks++;
        if (mid !== 4'd0) begin
            errors++;
            $display("FAIL basic_sum_held: sum mid-shift=%0d, required 0", mid);
        end
    endtask

    task automatic test_carry();
        int lat, bc, dc;
        logic [9:0] tr;
        logic [3:0] mid;
        run_add(4'd15, 4'd1, 1'b0, 1'b0, lat, bc, dc, tr, mid);
        checks++;
        if (sum !== 4'd0 || cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_15p1: sum=%0d cout=%b, required 0 1", sum, cout);
        end
        run_add(4'd9, 4'd6, 1'b1, 1'b0, lat, bc, dc, tr, mid);
        checks++;
        if (sum !== 4'd0 || cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_9p6p1: sum=%0d cout=%b, required 0 1", sum, cout);
        end
        run_add(4'd2, 4'd4, 1'b1, 1'b0, lat, bc, dc, tr, mid);
        checks++;
        if (sum !== 4'd7 || cout !== 1'b0) begin
            errors++;
            $display("FAIL cin_2p4p1: sum=%0d cout=%b, required 7 0", sum, cout);
        end
    endtask

    task automatic test_accumulate();
        int lat, bc, dc;
        logic [9:0] tr;
        logic [3:0] mid;
        run_add(4'd7, 4'd0, 1'b0, 1'b0, lat, bc, dc, tr, mid);
        checks++;
        if (sum !== 4'd7 || cout !== 1'b0) begin
            errors++;
            $display("FAIL acc_first: sum=%0d cout=%b, required 7 0", sum, cout);
        end
        // op_a deliberately different so that ignoring acc_mode shows up.
        run_add(4'd1, 4'd12, 1'b0, 1'b1, lat, bc, dc, tr, mid);
        checks++;
        if (sum !== 4'd3 || cout !== 1'b1) begin
            errors++;
            $display("FAIL acc_7p12: sum=%0d cout=%b, required 3 1", sum, cout);
        end
    endtask

    task automatic test_start_while_busy();
        int lat, dc;
        @(negedge clk);
        op_a = 4'd5; op_b = 4'd3; cin = 1'b0; acc_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; dc = 0;
        for (int j = 0; j < 12; j++) begin
            if (done) begin
                dc++;
                if (lat < 0) lat = j;
            end
            if (j == 1) begin
                @(negedge clk);
                start = 1'b1; op_a = 4'd15; op_b = 4'd15; cin = 1'b1;
            end else if (j == 2) begin
                @(negedge clk);
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (sum !== 4'd8 || cout !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_result: sum=%0d cout=%b, required 8 0", sum, cout);
        end
        checks++;
        if (dc !== 1 || lat !== 4) begin
            errors++;
            $display("FAIL busy_start_done: done_cycles=%0d latency=%0d, required 1 4", dc, lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_not_queued: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, dc, dseen;
        logic [9:0] tr;
        logic [3:0] mid;
        @(negedge clk);
        op_a = 4'd6; op_b = 4'd7; cin = 1'b0; acc_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bit_idx !== 2'd2) begin
            errors++;
            $display("FAIL mid_bit_idx: bit_idx=%0d, required 2", bit_idx);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 4'd0 || cout !== 1'b0 || bit_idx !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_state: busy=%b done=%b sum=%0d cout=%b idx=%0d, required all 0",
                     busy, done, sum, cout, bit_idx);
        end
        @(negedge clk);
        rst = 1'b0;
        dseen = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            if (done || busy) dseen++;
        end
        checks++;
        if (dseen !== 0) begin
            errors++;
            $display("FAIL mid_reset_no_done: active_cycles=%0d, required 0", dseen);
        end
        // Accumulate right after reset must start from 0.
        run_add(4'd9, 4'd5, 1'b0, 1'b1, lat, bc, dc, tr, mid);
        checks++;
        if (sum !== 4'd5 || cout !== 1'b0 || lat !== 4 || dc !== 1) begin
            errors++;
            $display("FAIL post_reset_add: sum=%0d cout=%b lat=%0d done=%0d, required 5 0 4 1",
                     sum, cout, lat, dc);
        end
    endtask

    task automatic test_random();
        int lat, bc, dc;
        logic [9:0] tr;
        logic [3:0] mid;
        logic [3:0] a, b;
        logic       c;
        logic [4:0] ref_v;
        for (int n = 0; n < 1000; n++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            c = 1'($urandom_range(0, 1));
            ref_v = 5'(a) + 5'(b) + 5'(c);
            run_add(a, b, c, 1'b0, lat, bc, dc, tr, mid);
            checks++;
            if ({cout, sum} !== ref_v) begin
                errors++;
                $display("FAIL rand_sum: %0d+%0d+%0d got {cout,sum}=%0d, required %0d",
                         a, b, c, {cout, sum}, ref_v);
            end
            checks++;
            if (lat !== 4 || dc !== 1 || bc !== 5) begin
                errors++;
                $display("FAIL rand_timing: lat=%0d done=%0d busy=%0d, required 4 1 5", lat, dc, bc);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_carry();
        test_accumulate();
        test_start_while_busy();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_add_sequencer
